// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and transmit FSM encoding shared by the I2S blocks.
package i2s_pkg;

    localparam int I2S_SLOT_WIDTH_DEF = 32;
    localparam int I2S_DATA_WIDTH_DEF = 24;

    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;

    typedef enum logic [1:0] {
        ST_SYNC  = SYNC,
        ST_LEFT  = LEFT,
        ST_RIGHT = RIGHT
    } tx_state_e;

endpackage

// File: rtl/i2s_edge_det.sv
// i2s_edge_det: SCLK falling-edge and LRCK slot-boundary detector in the MCLK
// domain. Shared by the transmit and (future) receive controllers.
module i2s_edge_det (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sclk_in,
    input  logic lrck_in,
    output logic sclk_fall_out,
    output logic boundary_out,
    output logic right_out
);

    logic sclk_q;
    logic sclk_d;
    logic lrck_fall_q;
    logic lrck_fall_d;

    // Detect the SCLK fall and compare LRCK with its value at the previous fall.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sclk_d        = sclk_in;
        lrck_fall_d   = lrck_fall_q;
        sclk_fall_out = sclk_q & ~sclk_in;
        boundary_out  = sclk_fall_out & (lrck_in != lrck_fall_q);
        right_out     = lrck_in;
        if (sclk_fall_out) begin
            lrck_fall_d = lrck_in;
        end
    end

    // Edge history registers; lrck_fall_q starts high so a low LRCK opens a left slot.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_in) begin
            sclk_q      <= 1'b0;
            lrck_fall_q <= 1'b1;
        end else begin
            sclk_q      <= sclk_d;
            lrck_fall_q <= lrck_fall_d;
        end
    end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: Philips I2S transmitter. Buffers one stereo pair and shifts it
// out MSB-first, one SCLK after each LRCK edge (LRCK low = left channel).
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add a saturating underrun counter.
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH_DEF,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      lrck_in,
    input  logic                      sclk_in,
    input  logic [2*DATA_WIDTH-1:0]   s_tdata_in,
    input  logic                      s_tvalid_in,
    output logic                      s_tready_out,
    output logic                      sdata_out,
    output logic                      underrun_out
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]               underrun_cnt_out
`endif
);

    logic sclk_fall;
    logic boundary;
    logic bnd_right;

    i2s_edge_det u_edge_det (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .sclk_in       (sclk_in),
        .lrck_in       (lrck_in),
        .sclk_fall_out (sclk_fall),
        .boundary_out  (boundary),
        .right_out     (bnd_right)
    );

    tx_state_e state_q, state_d;

    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_left_q,  hold_left_d;
    logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
    logic [DATA_WIDTH-1:0] right_buf_q,  right_buf_d;
    logic [SLOT_WIDTH-1:0] shift_q,      shift_d;
    logic                  sdata_q,      sdata_d;
    logic                  underrun_q,   underrun_d;

    logic left_bnd;
    logic right_bnd;
    logic left_load;
    logic right_load;
    logic accept;

    // Place a sample in the top bits of a slot word; the LSB side is zero padding.
    function automatic logic [SLOT_WIDTH-1:0] align_msb(input logic [DATA_WIDTH-1:0] w);
        logic [SLOT_WIDTH-1:0] r;
        r = '0;
        r[SLOT_WIDTH-1 -: DATA_WIDTH] = w;
        return r;
    endfunction

    assign left_bnd  = boundary & ~bnd_right;
    assign right_bnd = boundary &  bnd_right;
    assign accept    = s_tvalid_in & ~hold_valid_q;

    // Slot FSM: wait for the first left boundary, then alternate LEFT/RIGHT.
    always_comb begin
        state_d    = state_q;
        left_load  = 1'b0;
        right_load = 1'b0;
        unique case (state_q)
            ST_SYNC: begin
                if (left_bnd) begin
                    state_d   = ST_LEFT;
                    left_load = 1'b1;
                end
            end
            ST_LEFT: begin
                if (right_bnd) begin
                    state_d    = ST_RIGHT;
                    right_load = 1'b1;
                end
            end
            ST_RIGHT: begin
                if (left_bnd) begin
                    state_d   = ST_LEFT;
                    left_load = 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Datapath: shift on SCLK falls, load words at boundaries, fill the hold register.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        right_buf_d  = right_buf_q;
        shift_d      = shift_q;
        sdata_d      = sdata_q;
        underrun_d   = 1'b0;

        // The boundary fall still emits the old MSB, which delays the new word by one SCLK.
        if (sclk_fall && (state_q != ST_SYNC)) begin
            sdata_d = shift_q[SLOT_WIDTH-1];
            shift_d = shift_q << 1;
        end

        if (left_load) begin
            if (hold_valid_q) begin
                shift_d      = align_msb(hold_left_q);
                right_buf_d  = hold_right_q;
                hold_valid_d = 1'b0;
            end else begin
                shift_d     = '0;
                right_buf_d = '0;
                underrun_d  = 1'b1;
            end
        end

        if (right_load) begin
            shift_d = align_msb(right_buf_q);
        end

        // Only possible while the hold register is empty, so it never collides with a load that empties it.
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_left_d  = s_tdata_in[2*DATA_WIDTH-1:DATA_WIDTH];
            hold_right_d = s_tdata_in[DATA_WIDTH-1:0];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        // NOTE: data registers are cleared too, so a reset mid-frame leaves no stale word behind.
        if (rst_in) begin
            state_q      <= ST_SYNC;
            hold_valid_q <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            right_buf_q  <= '0;
            shift_q      <= '0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            right_buf_q  <= right_buf_d;
            shift_q      <= shift_d;
            sdata_q      <= sdata_d;
            underrun_q   <= underrun_d;
        end
    end

    assign s_tready_out = ~hold_valid_q;
    assign sdata_out    = sdata_q;
    assign underrun_out = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    // Saturating count of underrun pulses.
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt_out = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// tb_i2s_tx_ctrl: directed and random stimulus for i2s_tx_ctrl with a
// slot-level reference model (64 SCLK per frame, 4 MCLK per SCLK).
module tb_i2s_tx_ctrl;

    localparam int DW = 24;
    localparam int SW = 32;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic            rst_in;
    logic            lrck_in;
    logic            sclk_in;
    logic [2*DW-1:0] s_tdata_in;
    logic            s_tvalid_in;
    logic            s_tready_out;
    logic            sdata_out;
    logic            underrun_out;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]     underrun_cnt_out;
`endif

    // Clock generator stand-in: MCLK/4 SCLK, MCLK/256 LRCK, LRCK changes on an SCLK fall.
    logic [7:0] gen_cnt = 8'd140;
    always @(posedge clk_in) gen_cnt <= gen_cnt + 8'd1;
    assign sclk_in = gen_cnt[1];
    assign lrck_in = gen_cnt[7];

    i2s_tx_ctrl #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .lrck_in      (lrck_in),
        .sclk_in      (sclk_in),
        .s_tdata_in   (s_tdata_in),
        .s_tvalid_in  (s_tvalid_in),
        .s_tready_out (s_tready_out),
        .sdata_out    (sdata_out),
        .underrun_out (underrun_out)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_out (underrun_cnt_out)
`endif
    );

    int n_errors = 0;
    int n_checks = 0;

    // Reference model: slot words and a bit index counted from each load.
    bit            m_sclk_prev;
    bit            m_lr_prev;
    bit            m_synced;
    bit            m_pending;
    logic [DW-1:0] m_hl, m_hr, m_rbuf;
    logic [SW-1:0] m_word;
    int            m_k;
    logic          exp_sdata;
    logic          exp_underrun;

    logic          offer_v;
    logic [2*DW-1:0] offer_d;
    bit            stream_mode;

    logic [SW-1:0] rx_shift, rx_left, rx_right;
    int            n_und;
    int            n_acc_dut;
    logic [7:0]    last_c;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] slot_word(input logic [DW-1:0] w);
        return {w, {(SW-DW){1'b0}}};
    endfunction

    task automatic model_reset();
        m_sclk_prev  = 1'b0;
        m_lr_prev    = 1'b1;
        m_synced     = 1'b0;
        m_pending    = 1'b0;
        m_hl         = '0;
        m_hr         = '0;
        m_rbuf       = '0;
        m_word       = '0;
        m_k          = 0;
        exp_sdata    = 1'b0;
        exp_underrun = 1'b0;
    endtask

    // Advance the model over the cycle whose generator count is c.
    task automatic model_step(input logic [7:0] c, input logic r);
        logic sclk, lrck, fall, bnd, acc;
        logic [63:0] rnd;
        sclk = c[1];
        lrck = c[7];
        if (r) begin
            model_reset();
            return;
        end
        fall         = m_sclk_prev & ~sclk;
        m_sclk_prev  = sclk;
        acc          = offer_v & ~m_pending;
        exp_underrun = 1'b0;
        if (fall) begin
            bnd       = (lrck != m_lr_prev);
            m_lr_prev = lrck;
            if (m_synced) begin
                exp_sdata = (m_k < SW) ? m_word[SW-1-m_k] : 1'b0;
                m_k++;
            end
            if (bnd && !lrck) begin
                m_synced = 1'b1;
                m_k      = 0;
                if (m_pending) begin
                    m_word    = slot_word(m_hl);
                    m_rbuf    = m_hr;
                    m_pending = 1'b0;
                end else begin
                    m_word       = '0;
                    m_rbuf       = '0;
                    exp_underrun = 1'b1;
                end
            end else if (bnd && lrck && m_synced) begin
                m_word = slot_word(m_rbuf);
                m_k    = 0;
            end
        end
        if (acc) begin
            m_pending  = 1'b1;
            m_hl       = offer_d[2*DW-1:DW];
            m_hr       = offer_d[DW-1:0];
            if (stream_mode) begin
                rnd     = {$urandom, $urandom};
                offer_d = rnd[2*DW-1:0];
            end else begin
                offer_v = 1'b0;
            end
        end
    endtask

    // One MCLK cycle: compare outputs, capture serial bits, drive inputs, step the model.
    task automatic tick(input logic r);
        logic [7:0] c;
        @(negedge clk_in);
        c      = gen_cnt;
        last_c = c;
        check1("sdata_out", sdata_out, exp_sdata);
        check1("underrun_out", underrun_out, exp_underrun);
        check1("s_tready_out", s_tready_out, ~m_pending);
        if (underrun_out === 1'b1) n_und++;
        if (c[1:0] == 2'd1) rx_shift = {rx_shift[SW-2:0], sdata_out};
        if (c == 8'd129) rx_left  = rx_shift;
        if (c == 8'd1)   rx_right = rx_shift;
        rst_in      = r;
        s_tvalid_in = offer_v;
        s_tdata_in  = offer_d;
        if (offer_v && (s_tready_out === 1'b1) && !r) n_acc_dut++;
        model_step(c, r);
    endtask

    task automatic run_until(input logic [7:0] t);
        int guard;
        guard = 0;
        do begin
            tick(1'b0);
            guard++;
        end while ((last_c != t) && (guard < 600));
        check32("run_until_cnt", 32'(last_c), 32'(t));
    endtask

    initial begin
        int und0;
        model_reset();
        offer_v     = 1'b0;
        offer_d     = '0;
        stream_mode = 1'b0;
        rx_shift    = '0;
        rx_left     = '0;
        rx_right    = '0;
        n_und       = 0;
        n_acc_dut   = 0;
        last_c      = '0;
        rst_in      = 1'b1;
        s_tvalid_in = 1'b0;
        s_tdata_in  = '0;
        repeat (3) @(posedge clk_in);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check1("reset_sdata", sdata_out, 1'b0);
        check1("reset_tready", s_tready_out, 1'b1);
        check1("reset_underrun", underrun_out, 1'b0);

        // One pair offered before the first left boundary.
        offer_v = 1'b1;
        offer_d = 48'hA5A5A5_5A5A5A;
        run_until(8'd0);
        run_until(8'd129);
        check32("first_left_word", rx_left, 32'hA5A5A500);
        check32("first_no_underrun", 32'(n_und), 32'd0);
        und0 = n_und;
        run_until(8'd1);
        check32("first_right_word", rx_right, 32'h5A5A5A00);

        // No data: one underrun per frame, zeros on the line.
        run_until(8'd1);
        run_until(8'd1);
        check32("idle_underruns", 32'(n_und - und0), 32'd3);
        check32("idle_left_zero", rx_left, 32'h0);
        check32("idle_right_zero", rx_right, 32'h0);
        run_until(8'd2);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check32("underrun_cnt", 32'(underrun_cnt_out), 32'd3);
        force dut.underrun_cnt_q = 16'hFFFF;
        tick(1'b0);
        tick(1'b0);
        release dut.underrun_cnt_q;
        run_until(8'd2);
        check32("underrun_cnt_sat", 32'(underrun_cnt_out), 32'hFFFF);
`endif

        // Back-to-back random pairs: initial fill plus one refill per left load.
        stream_mode = 1'b1;
        offer_v     = 1'b1;
        offer_d     = 48'h13579B_2468AC;
        n_acc_dut   = 0;
        repeat (4 * 256) tick(1'b0);
        check32("stream_accepts", 32'(n_acc_dut), 32'd5);
        stream_mode = 1'b0;
        offer_v     = 1'b0;
        run_until(8'd0);
        run_until(8'd255);

        // Pair first offered in the left-load cycle: this frame underruns, next frame sends it.
        offer_v = 1'b1;
        offer_d = 48'h123456_789ABC;
        und0    = n_und;
        run_until(8'd1);
        check32("late_pair_underrun", 32'(n_und - und0), 32'd1);
        run_until(8'd129);
        check32("late_pair_frame_zero", rx_left, 32'h0);
        run_until(8'd129);
        check32("late_pair_left", rx_left, 32'h12345600);
        run_until(8'd1);
        check32("late_pair_right", rx_right, 32'h789ABC00);

        // Reset mid-left-slot with a word shifting and another pair held.
        offer_v = 1'b1;
        offer_d = 48'hC3C3C3_3C3C3C;
        run_until(8'd0);
        offer_v = 1'b1;
        offer_d = 48'hDEADBE_EF0123;
        run_until(8'd60);
        check1("pre_reset_tready", s_tready_out, 1'b0);
        und0 = n_und;
        tick(1'b1);
        tick(1'b0);
        check1("post_reset_sdata", sdata_out, 1'b0);
        check1("post_reset_tready", s_tready_out, 1'b1);
        run_until(8'd70);
        check32("post_reset_resync_underrun", 32'(n_und - und0), 32'd1);
        offer_v = 1'b1;
        offer_d = 48'h0F1E2D_3C4B5A;
        run_until(8'd0);
        run_until(8'd129);
        check32("post_reset_left", rx_left, 32'h0F1E2D00);
        run_until(8'd1);
        check32("post_reset_right", rx_right, 32'h3C4B5A00);
        run_until(8'd8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
